// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, scan-code set 2 constants, frame length.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int FRAME_LEN = 11;

  // Keyboard housekeeping bytes that never describe a key.
  function automatic logic is_filler(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes the PS/2 pins, debounces the PS/2 clock and emits a strobe on its falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic dat,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_filt;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             toggle;

  assign differs = (clk_sync[1] != clk_filt);
  assign toggle  = differs && (cnt == CNT_W'(FILTER_LEN - 1));
  assign dat     = dat_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchronizers and filter reset to 1 (idle bus), so release from reset never fakes a fall.
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value of its neighbour.
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      fall     <= toggle && clk_filt;
      if (!differs) begin
        cnt <= '0;
      end else if (toggle) begin
        clk_filt <= ~clk_filt;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: frame FSM with parity/framing/timeout checks and a scan-code set 2 decoder.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  ps2_state_e      state_q, state_d;
  logic            dat;
  logic            fall;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [TO_W-1:0] to_cnt;
  logic            stop_seen;
  logic            timeout_hit;
  logic            frame_good;
  logic            ext_pend;
  logic            brk_pend;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .dat       (dat),
    .fall      (fall)
  );

  assign busy       = (state_q != IDLE);
  assign frame_good = dat && (^{shift_q, parity_q});

  // A fall takes priority over the timeout so a late-but-valid edge keeps the frame alive.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    stop_seen   = 1'b0;
    timeout_hit = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE:   if (!dat) state_d = DATA;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d   = IDLE;
          stop_seen = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      to_cnt   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_valid <= stop_seen && frame_good;
      rx_err   <= (stop_seen && !frame_good) || timeout_hit;
      to_cnt   <= (fall || state_q == IDLE) ? '0 : to_cnt + 1'b1;
      if (fall) begin
        if (state_q == IDLE) bit_cnt <= '0;
        if (state_q == DATA) begin
          shift_q <= {dat, shift_q[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state_q == PARITY) parity_q <= dat;
      end
      if (stop_seen && frame_good) rx_byte <= shift_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (rx_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else if (is_filler(rx_byte)) begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else begin
          key_code  <= rx_byte;
          key_ext   <= ext_pend;
          key_break <= brk_pend;
          key_valid <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: table of whole frames plus timeout, glitch and reset sequences.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic       rx_valid, rx_err, key_ext, key_break, key_valid, busy;

  ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .ps2_clk_in(ps2_clk),
    .ps2_dat_in(ps2_dat),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_valid = 0, n_err = 0, n_key = 0, n_busy = 0;
  int last_valid_cyc = 0, last_err_cyc = 0, last_key_cyc = 0;
  int last_low_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid)  begin n_valid++; last_valid_cyc = cyc; end
    if (rx_err)    begin n_err++;   last_err_cyc   = cyc; end
    if (key_valid) begin n_key++;   last_key_cyc   = cyc; end
    if (busy)      n_busy++;
  end

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_byte;
    int         exp_key;
    logic [7:0] exp_code;
    logic       exp_ext;
    logic       exp_brk;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] data, input logic bad_par,
                                             input logic stop);
    logic par;
    par = ~(^data) ^ bad_par;
    return {stop, par, data, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      last_low_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
    end
    ps2_dat = 1'b1;
  endtask

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

  initial begin
    int nv, ne, nk, nb, t0;

    vec[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1, 8'h1C, 1'b0, 1'b0};
    vec[1] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 0, 8'h1C, 1'b0, 1'b0};
    vec[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1, 8'h1C, 1'b0, 1'b1};
    vec[3] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0, 0, 8'h1C, 1'b0, 1'b1};
    vec[4] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 0, 8'h1C, 1'b0, 1'b1};
    vec[5] = '{8'h74, 1'b0, 1'b1, 1, 0, 8'h74, 1, 8'h74, 1'b1, 1'b1};
    vec[6] = '{8'h29, 1'b0, 1'b1, 1, 0, 8'h29, 1, 8'h29, 1'b0, 1'b0};
    vec[7] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h29, 0, 8'h29, 1'b0, 1'b0};
    vec[8] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h29, 0, 8'h29, 1'b0, 1'b0};
    vec[9] = '{8'hAA, 1'b0, 1'b1, 1, 0, 8'hAA, 0, 8'h29, 1'b0, 1'b0};

    // Reset state
    wait_cyc(5);
    check("reset_outputs", {rx_byte, rx_valid, rx_err, key_code, key_ext, key_break, key_valid, busy}, '0);
    rst_n = 1'b1;
    wait_cyc(20);
    check("post_reset_outputs", {rx_byte, rx_valid, rx_err, key_code, key_ext, key_break, key_valid, busy}, '0);

    // Table of whole frames
    for (int i = 0; i < 10; i++) begin
      nv = n_valid; ne = n_err; nk = n_key;
      ps2_bits(make_frame(vec[i].data, vec[i].bad_par, vec[i].stop), FRAME_LEN);
      wait_cyc(20);
      check($sformatf("row%0d_valid_cnt", i), n_valid - nv, vec[i].exp_valid);
      check($sformatf("row%0d_err_cnt", i), n_err - ne, vec[i].exp_err);
      check($sformatf("row%0d_key_cnt", i), n_key - nk, vec[i].exp_key);
      check($sformatf("row%0d_rx_byte", i), rx_byte, vec[i].exp_byte);
      check($sformatf("row%0d_key", i), {key_code, key_ext, key_break},
            {vec[i].exp_code, vec[i].exp_ext, vec[i].exp_brk});
      check($sformatf("row%0d_busy", i), busy, 1'b0);
      if (vec[i].exp_key == 1)
        check($sformatf("row%0d_key_latency", i), last_key_cyc - last_valid_cyc, 1);
    end

    // Timeout mid-frame after an E0 prefix: error pulse, flags cleared
    ps2_bits(make_frame(PS2_EXT, 1'b0, 1'b1), FRAME_LEN);
    wait_cyc(20);
    nv = n_valid; ne = n_err; nk = n_key;
    ps2_bits(make_frame(8'h55, 1'b0, 1'b1), 5);
    t0 = last_low_cyc;
    check("timeout_busy_mid", busy, 1'b1);
    wait_cyc(250);
    check("timeout_err_cnt", n_err - ne, 1);
    check("timeout_valid_cnt", n_valid - nv, 0);
    check("timeout_busy", busy, 1'b0);
    check("timeout_window", ((last_err_cyc - t0) >= 205) && ((last_err_cyc - t0) <= 218), 1'b1);
    ps2_bits(make_frame(8'h29, 1'b0, 1'b1), FRAME_LEN);
    wait_cyc(20);
    check("after_timeout_valid_cnt", n_valid - nv, 1);
    check("after_timeout_rx_byte", rx_byte, 8'h29);
    check("after_timeout_key_cnt", n_key - nk, 1);
    check("after_timeout_key", {key_code, key_ext, key_break}, {8'h29, 1'b0, 1'b0});

    // Short clock glitch while idle, then a BAT byte
    nv = n_valid; ne = n_err; nk = n_key; nb = n_busy;
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("glitch_busy_cycles", n_busy - nb, 0);
    check("glitch_pulses", (n_valid - nv) + (n_err - ne) + (n_key - nk), 0);
    ps2_bits(make_frame(PS2_BAT, 1'b0, 1'b1), FRAME_LEN);
    wait_cyc(20);
    check("bat_valid_cnt", n_valid - nv, 1);
    check("bat_rx_byte", rx_byte, 8'hAA);
    check("bat_key_cnt", n_key - nk, 0);

    // Reset in the middle of a frame
    nv = n_valid; ne = n_err; nk = n_key;
    ps2_bits(make_frame(8'h1C, 1'b0, 1'b1), 7);
    check("midreset_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midreset_outputs", {rx_byte, rx_valid, rx_err, key_code, key_ext, key_break, key_valid, busy}, '0);
    rst_n = 1'b1;
    wait_cyc(20);
    ps2_bits(make_frame(8'h1C, 1'b0, 1'b1), FRAME_LEN);
    wait_cyc(20);
    check("midreset_valid_cnt", n_valid - nv, 1);
    check("midreset_err_cnt", n_err - ne, 0);
    check("midreset_rx_byte", rx_byte, 8'h1C);
    check("midreset_key", {key_code, key_ext, key_break}, {8'h1C, 1'b0, 1'b0});
    check("midreset_key_cnt", n_key - nk, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
